// File: rtl/pong_match_ctrl.sv
// Match sequencer for two-player pong: round flow, ball gating/recentre, scores, winner.
// Optional build macro MATCH_WIN_BY_TWO_EN: winning additionally requires a lead of two.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 120,
  parameter int unsigned GOAL_FRAMES  = 60
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_animate,
  input  logic       i_start,
  input  logic       i_goal_player_1,
  input  logic       i_goal_player_2,
  output logic       o_ball_enable,
  output logic       o_ball_reset,
  output logic       o_serve_dir,
  output logic [3:0] o_score_player_1,
  output logic [3:0] o_score_player_2,
  output logic [1:0] o_winner,
  output logic [2:0] o_state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_GOAL  = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] GOAL_LOAD  = 8'(GOAL_FRAMES - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] score1_q, score1_d;
  logic [3:0] score2_q, score2_d;
  logic [1:0] winner_q, winner_d;
  logic       serve_dir_q, serve_dir_d;
  logic       ball_en_q, ball_en_d;
  logic       ball_rst_q, ball_rst_d;
  logic       start_q, start_d;

  logic       start_rise;
  logic [3:0] score1_inc, score2_inc;
  logic       p1_wins, p2_wins;

  assign start_rise = i_start & ~start_q;
  assign score1_inc = (score1_q == 4'hF) ? 4'hF : score1_q + 4'd1;
  assign score2_inc = (score2_q == 4'hF) ? 4'hF : score2_q + 4'd1;

`ifdef MATCH_WIN_BY_TWO_EN
  // Reaching 15 with any lead wins, otherwise saturation could stall the match forever.
  assign p1_wins = ((score1_inc >= WIN_VAL) &&
                    ({1'b0, score1_inc} >= ({1'b0, score2_q} + 5'd2))) ||
                   ((score1_inc == 4'hF) && (score1_inc > score2_q));
  assign p2_wins = ((score2_inc >= WIN_VAL) &&
                    ({1'b0, score2_inc} >= ({1'b0, score1_q} + 5'd2))) ||
                   ((score2_inc == 4'hF) && (score2_inc > score1_q));
`else
  assign p1_wins = (score1_inc == WIN_VAL);
  assign p2_wins = (score2_inc == WIN_VAL);
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    winner_d    = winner_q;
    serve_dir_d = serve_dir_q;
    ball_rst_d  = 1'b0;
    start_d     = i_start;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          score1_d   = '0;
          score2_d   = '0;
          winner_d   = 2'b00;
          ball_rst_d = 1'b1;
          cnt_d      = SERVE_LOAD;
          state_d    = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (i_animate) begin
          if (cnt_q == '0) state_d = ST_PLAY;
          else             cnt_d   = cnt_q - 8'd1;
        end
      end
      ST_PLAY: begin
        if (i_goal_player_1 && i_goal_player_2) begin
          state_d = ST_GOAL;
          cnt_d   = GOAL_LOAD;
        end else if (i_goal_player_1) begin
          score1_d    = score1_inc;
          serve_dir_d = 1'b1;
          if (p1_wins) begin
            state_d  = ST_OVER;
            winner_d = 2'b01;
          end else begin
            state_d = ST_GOAL;
            cnt_d   = GOAL_LOAD;
          end
        end else if (i_goal_player_2) begin
          score2_d    = score2_inc;
          serve_dir_d = 1'b0;
          if (p2_wins) begin
            state_d  = ST_OVER;
            winner_d = 2'b10;
          end else begin
            state_d = ST_GOAL;
            cnt_d   = GOAL_LOAD;
          end
        end
      end
      ST_GOAL: begin
        if (i_animate) begin
          if (cnt_q == '0) begin
            ball_rst_d = 1'b1;
            cnt_d      = SERVE_LOAD;
            state_d    = ST_SERVE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Enable is registered from the next state so it drops on the edge that records a goal.
    ball_en_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      score1_q    <= '0;
      score2_q    <= '0;
      winner_q    <= 2'b00;
      serve_dir_q <= 1'b0;
      ball_en_q   <= 1'b0;
      ball_rst_q  <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      winner_q    <= winner_d;
      serve_dir_q <= serve_dir_d;
      ball_en_q   <= ball_en_d;
      ball_rst_q  <= ball_rst_d;
      start_q     <= start_d;
    end
  end

  assign o_state          = state_q;
  assign o_score_player_1 = score1_q;
  assign o_score_player_2 = score2_q;
  assign o_winner         = winner_q;
  assign o_serve_dir      = serve_dir_q;
  assign o_ball_enable    = ball_en_q;
  assign o_ball_reset     = ball_rst_q;

endmodule
